// File: rtl/bcd_pkg.sv
// Shared BCD constants and a digit-validity helper used by the counter and its digits.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input logic [DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One decade of the cascaded BCD up/down counter; passes a count enable to the next decade.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               cnt_in,
  input  logic               up,
  output logic [DIGIT_W-1:0] digit,
  output logic               cnt_out
);
  logic [DIGIT_W-1:0] digit_d;
  logic [DIGIT_W-1:0] digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      // Illegal nibbles collapse to zero so q never leaves 0..9.
      digit_d = bcd_valid(load_digit) ? load_digit : BCD_MIN;
    end else if (cnt_in) begin
      if (up) digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      else    digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) digit_q <= BCD_MIN;
    else       digit_q <= digit_d;
  end

  assign digit   = digit_q;
  assign cnt_out = cnt_in & (up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));
endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded DIGITS-decade BCD up/down counter with parallel load, terminal count and wrap pulse.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  output logic [DIGIT_W*DIGITS-1:0] q,
  output logic                    tc,
  output logic                    wrap,
  output logic                    load_err
);
  logic [DIGITS:0] carry;
  logic            all_max;
  logic            all_min;
  logic            bad_nibble;
  logic            wrap_d, wrap_q;
  logic            load_err_d, load_err_q;

  // Load suppresses counting at the chain head, so no wrap can ripple out.
  assign carry[0] = en & ~load;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_digit (load_val[i*DIGIT_W +: DIGIT_W]),
      .cnt_in     (carry[i]),
      .up         (up),
      .digit      (q[i*DIGIT_W +: DIGIT_W]),
      .cnt_out    (carry[i+1])
    );
  end

  always_comb begin
    all_max    = 1'b1;
    all_min    = 1'b1;
    bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (q[i*DIGIT_W +: DIGIT_W] != BCD_MAX) all_max = 1'b0;
      if (q[i*DIGIT_W +: DIGIT_W] != BCD_MIN) all_min = 1'b0;
      if (!bcd_valid(load_val[i*DIGIT_W +: DIGIT_W])) bad_nibble = 1'b1;
    end
  end

  assign tc = en & (up ? all_max : all_min);

  always_comb begin
    wrap_d     = carry[DIGITS];
    load_err_d = load & bad_nibble;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: stimulus pushes expected post-edge state, a monitor pops and compares each cycle.
module tb_bcd_updown_counter;
  logic        clk = 1'b0;
  logic        reset = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] q;
  logic        tc, wrap, load_err;

  logic        reset1 = 1'b1, en1 = 1'b0, up1 = 1'b1, load1 = 1'b0;
  logic [3:0]  load_val1 = '0;
  logic [3:0]  q1;
  logic        tc1, wrap1, load_err1;

  typedef struct {
    logic [15:0] q;
    logic        wrap;
    logic        lerr;
    logic        tc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t sb1[$];
  int   checks = 0;
  int   failures = 0;
  int   fail_prints = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(4)) u_dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  bcd_updown_counter #(.DIGITS(1)) u_dut1 (
    .clk(clk), .reset(reset1), .en(en1), .up(up1), .load(load1), .load_val(load_val1),
    .q(q1), .tc(tc1), .wrap(wrap1), .load_err(load_err1)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (fail_prints < 40) begin
        $display("FAIL %s actual=%h expected=%h", name, act, exp);
        fail_prints++;
      end
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic step(input logic r, input logic l, input logic e, input logic u,
                      input logic [15:0] lv, input logic [15:0] eq,
                      input logic ew, input logic el, input string name);
    exp_t x;
    @(negedge clk);
    reset = r; load = l; en = e; up = u; load_val = lv;
    x.q = eq; x.wrap = ew; x.lerr = el;
    x.tc = e & (u ? (eq == 16'h9999) : (eq == 16'h0000));
    x.name = name;
    sb.push_back(x);
  endtask

  task automatic step1(input logic r, input logic l, input logic e, input logic u,
                       input logic [3:0] lv, input logic [3:0] eq,
                       input logic ew, input logic el, input string name);
    exp_t x;
    @(negedge clk);
    reset1 = r; load1 = l; en1 = e; up1 = u; load_val1 = lv;
    x.q = {12'h000, eq}; x.wrap = ew; x.lerr = el;
    x.tc = e & (u ? (eq == 4'h9) : (eq == 4'h0));
    x.name = name;
    sb1.push_back(x);
  endtask

  // Monitor: one expected entry per clock edge while stimulus is active.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, "_q"},    q,                 e.q);
        check({e.name, "_wrap"}, {15'd0, wrap},     {15'd0, e.wrap});
        check({e.name, "_lerr"}, {15'd0, load_err}, {15'd0, e.lerr});
        check({e.name, "_tc"},   {15'd0, tc},       {15'd0, e.tc});
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        check({e.name, "_q"},    {12'd0, q1},        e.q);
        check({e.name, "_wrap"}, {15'd0, wrap1},     {15'd0, e.wrap});
        check({e.name, "_lerr"}, {15'd0, load_err1}, {15'd0, e.lerr});
        check({e.name, "_tc"},   {15'd0, tc1},       {15'd0, e.tc});
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, including priority over load/en and tc after reset.
    step(1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, "rst");
    step(1, 1, 1, 1, 16'h1234, 16'h0000, 0, 0, "rst_pri");
    step(1, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, "rst_tc");
    step(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, "hold0");

    // Full up sweep 0001..9999, 0000 with one wrap.
    for (int k = 1; k <= 10000; k++)
      step(0, 0, 1, 1, 16'h0000, to_bcd(k % 10000), (k == 10000), 0, "sweep");

    // Down-count borrow and underflow wrap.
    step(0, 1, 0, 0, 16'h0100, 16'h0100, 0, 0, "ld0100");
    step(0, 0, 1, 0, 16'h0000, 16'h0099, 0, 0, "dn1");
    step(0, 0, 1, 0, 16'h0000, 16'h0098, 0, 0, "dn2");
    step(0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, "ld0000");
    step(0, 0, 1, 0, 16'h0000, 16'h9999, 1, 0, "dnwrap");
    step(0, 0, 0, 0, 16'h0000, 16'h9999, 0, 0, "hold1");

    // Invalid nibble load.
    step(0, 1, 0, 1, 16'h12A9, 16'h1209, 0, 1, "ldbad");
    step(0, 0, 0, 1, 16'h0000, 16'h1209, 0, 0, "lerr_clr");

    // Load wins over count at 9999.
    step(0, 1, 0, 1, 16'h9999, 16'h9999, 0, 0, "ld9999");
    step(0, 1, 1, 1, 16'h0500, 16'h0500, 0, 0, "ldpri");

    // Reset mid-count.
    step(0, 1, 0, 1, 16'h0018, 16'h0018, 0, 0, "ld0018");
    step(0, 0, 1, 1, 16'h0000, 16'h0019, 0, 0, "up19");
    step(1, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, "midrst");
    step(0, 0, 1, 1, 16'h0000, 16'h0001, 0, 0, "resume");

    // Direction changes take effect on the same edge.
    step(0, 1, 0, 1, 16'h0010, 16'h0010, 0, 0, "ld0010");
    step(0, 0, 1, 1, 16'h0000, 16'h0011, 0, 0, "dir_u");
    step(0, 0, 1, 0, 16'h0000, 16'h0010, 0, 0, "dir_d1");
    step(0, 0, 1, 0, 16'h0000, 16'h0009, 0, 0, "dir_d2");
    step(0, 0, 1, 1, 16'h0000, 16'h0010, 0, 0, "dir_u2");
    step(0, 0, 0, 1, 16'h0000, 16'h0010, 0, 0, "hold2");

    // Single-digit instance smoke test.
    step1(1, 0, 0, 1, 4'h0, 4'h0, 0, 0, "d1_rst");
    step1(0, 1, 0, 1, 4'h8, 4'h8, 0, 0, "d1_ld8");
    step1(0, 0, 1, 1, 4'h0, 4'h9, 0, 0, "d1_up9");
    step1(0, 0, 1, 1, 4'h0, 4'h0, 1, 0, "d1_wrapup");
    step1(0, 0, 1, 0, 4'h0, 4'h9, 1, 0, "d1_wrapdn");
    step1(0, 1, 0, 1, 4'hC, 4'h0, 0, 1, "d1_ldbad");

    @(negedge clk);
    @(negedge clk);
    check("drain", 16'(sb.size() + sb1.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
